// File: rtl/dmem_pkg.sv
// Shared types and defaults for the data-memory responder and its storage.
package dmem_pkg;

  localparam int unsigned DATA_W         = 32;
  localparam int unsigned CNT_W          = 4;
  localparam int unsigned LATENCY_DEF    = 4;
  localparam int unsigned DEPTH_LOG2_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Request captured at acceptance so later input changes cannot disturb it.
  typedef struct packed {
    logic              write;
    logic [DATA_W-1:0] data;
  } op_t;

endpackage

// File: rtl/dmem_array.sv
// Word-addressed storage: synchronous write, combinational read, never reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
  input  logic                  clk_i,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata_c
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata_c = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: accepts one aligned load/store, stalls the
// pipeline for the access latency, then pulses ack_o (or err_o on a bad request).
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned LATENCY    = LATENCY_DEF,
  parameter int unsigned DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              mem_read_i,
  input  logic              mem_write_i,
  input  logic [DATA_W-1:0] addr_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              stall_o,
  output logic [DATA_W-1:0] data_o,
  output logic              ack_o,
  output logic              err_o
);

  state_t                state, state_n;
  logic [CNT_W-1:0]      cnt, cnt_n;
  op_t                   op, op_n;
  logic [DEPTH_LOG2-1:0] idx, idx_n;
  logic [DATA_W-1:0]     data_n;
  logic                  ack_n, err_n;
  logic                  we_c;
  logic [DATA_W-1:0]     rdata_c;
  logic                  req_c, mis_c, bad_c;
  logic                  unused_c;

  assign req_c = mem_read_i ^ mem_write_i;
  assign mis_c = addr_i[1:0] != 2'b00;
  assign bad_c = (mem_read_i & mem_write_i) | (req_c & mis_c);

  // Address bits above the word index are deliberately ignored (wrap-around).
  assign unused_c = ^addr_i[DATA_W-1:DEPTH_LOG2+2];

  // Held low during reset so a request present at reset cannot freeze the pipe.
  assign stall_o = rst_i & (((state == ST_IDLE) & req_c & ~mis_c) | (state == ST_BUSY));

  dmem_array #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_array (
    .clk_i   (clk_i),
    .we      (we_c),
    .addr    (idx),
    .wdata   (op.data),
    .rdata_c (rdata_c)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      op     <= '0;
      idx    <= '0;
      data_o <= '0;
      ack_o  <= 1'b0;
      err_o  <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      op     <= op_n;
      idx    <= idx_n;
      data_o <= data_n;
      ack_o  <= ack_n;
      err_o  <= err_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    op_n    = op;
    idx_n   = idx;
    data_n  = data_o;
    ack_n   = 1'b0;
    err_n   = 1'b0;
    we_c    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req_c && !mis_c) begin
          state_n    = ST_BUSY;
          cnt_n      = CNT_W'(LATENCY);
          op_n.write = mem_write_i;
          op_n.data  = data_i;
          idx_n      = addr_i[DEPTH_LOG2+1:2];
        end else if (bad_c) begin
          err_n = 1'b1;
        end
      end
      ST_BUSY: begin
        cnt_n = cnt - CNT_W'(1);
        // Commit on the last busy cycle so results are visible in DONE.
        if (cnt == CNT_W'(1)) begin
          state_n = ST_DONE;
          ack_n   = 1'b1;
          if (op.write) begin
            we_c = 1'b1;
          end else begin
            data_n = rdata_c;
          end
        end
      end
      ST_DONE: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder using a load-data scoreboard queue.
module tb_dmem_responder;

  localparam int L = 4;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        mem_read_i, mem_write_i;
  logic [31:0] addr_i, data_i;
  logic        stall_o, ack_o, err_o;
  logic [31:0] data_o;

  logic        rd1, wr1;
  logic [31:0] addr1, data1;
  logic        stall1, ack1, err1;
  logic [31:0] dout1;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q [$];
  logic [31:0] model [256];
  logic [31:0] last_ld = 32'h0;

  always #5 clk_i = ~clk_i;

  dmem_responder #(.LATENCY(L), .DEPTH_LOG2(8)) u_dut (
    .clk_i(clk_i), .rst_i(rst_i), .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
    .addr_i(addr_i), .data_i(data_i), .stall_o(stall_o), .data_o(data_o),
    .ack_o(ack_o), .err_o(err_o)
  );

  dmem_responder #(.LATENCY(1), .DEPTH_LOG2(8)) u_lat1 (
    .clk_i(clk_i), .rst_i(rst_i), .mem_read_i(rd1), .mem_write_i(wr1),
    .addr_i(addr1), .data_i(data1), .stall_o(stall1), .data_o(dout1),
    .ack_o(ack1), .err_o(err1)
  );

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic idle(input int n);
    @(posedge clk_i); #1;
    mem_read_i = 1'b0; mem_write_i = 1'b0;
    repeat (n) @(posedge clk_i);
  endtask

  // One aligned access; the request stays asserted through DONE.
  task automatic access(input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
    logic [7:0]  idx;
    logic [31:0] exp_v;
    idx = addr[9:2];
    @(posedge clk_i); #1;
    mem_read_i = ~wr; mem_write_i = wr; addr_i = addr; data_i = wdata;
    if (!wr) exp_q.push_back(model[idx]);
    for (int k = 0; k <= L + 1; k++) begin
      @(negedge clk_i);
      checks++;
      if (stall_o !== (k <= L)) begin
        errors++; $display("FAIL stall addr=%h k=%0d got %b exp %b", addr, k, stall_o, (k <= L));
      end
      checks++;
      if (ack_o !== (k == L + 1)) begin
        errors++; $display("FAIL ack addr=%h k=%0d got %b exp %b", addr, k, ack_o, (k == L + 1));
      end
      if (k == 1) begin
        addr_i = addr ^ 32'h0000_0ffc; data_i = ~wdata;
      end
      if (k == L + 1) begin
        if (wr) begin
          model[idx] = wdata;
          exp_v = last_ld;
        end else begin
          exp_v = exp_q.pop_front();
          last_ld = exp_v;
        end
        checks++;
        if (data_o !== exp_v) begin
          errors++; $display("FAIL data_o addr=%h wr=%b got %h exp %h", addr, wr, data_o, exp_v);
        end
      end
    end
  endtask

  task automatic bad_req(input logic rd, input logic wr, input logic [31:0] addr);
    @(posedge clk_i); #1;
    mem_read_i = rd; mem_write_i = wr; addr_i = addr; data_i = 32'h0bad0bad;
    @(negedge clk_i);
    checks++;
    if (stall_o !== 1'b0 || err_o !== 1'b0) begin
      errors++; $display("FAIL bad_req_T addr=%h got stall=%b err=%b exp 0 0", addr, stall_o, err_o);
    end
    @(posedge clk_i); #1;
    mem_read_i = 1'b0; mem_write_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if (err_o !== 1'b1 || stall_o !== 1'b0 || ack_o !== 1'b0) begin
      errors++; $display("FAIL bad_req_T1 addr=%h got err=%b stall=%b ack=%b exp 1 0 0", addr, err_o, stall_o, ack_o);
    end
    checks++;
    if (data_o !== last_ld) begin
      errors++; $display("FAIL bad_req_data got %h exp %h", data_o, last_ld);
    end
    @(negedge clk_i);
    checks++;
    if (err_o !== 1'b0) begin
      errors++; $display("FAIL bad_req_T2 err got %b exp 0", err_o);
    end
  endtask

  task automatic test_reset;
    rst_i = 1'b0; mem_read_i = 1'b1; mem_write_i = 1'b0; addr_i = 32'h10; data_i = 32'h0;
    rd1 = 1'b0; wr1 = 1'b0; addr1 = 32'h0; data1 = 32'h0;
    repeat (3) @(negedge clk_i);
    checks++;
    if (stall_o !== 1'b0 || ack_o !== 1'b0 || err_o !== 1'b0 || data_o !== 32'h0) begin
      errors++; $display("FAIL reset got stall=%b ack=%b err=%b data=%h exp 0", stall_o, ack_o, err_o, data_o);
    end
    mem_read_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1;
    last_ld = 32'h0;
  endtask

  task automatic test_store_load;
    access(1'b1, 32'h10, 32'hdeadbeef);
    access(1'b0, 32'h10, 32'h0);
    idle(2);
  endtask

  task automatic test_wrap;
    access(1'b1, 32'h400, 32'h12345678);
    access(1'b0, 32'h0, 32'h0);
    idle(1);
  endtask

  task automatic test_misaligned;
    bad_req(1'b1, 1'b0, 32'h13);
  endtask

  task automatic test_both;
    bad_req(1'b1, 1'b1, 32'h10);
    access(1'b0, 32'h10, 32'h0);
    idle(1);
  endtask

  task automatic test_back_to_back;
    access(1'b1, 32'h44, 32'h55aa55aa);
    access(1'b0, 32'h44, 32'h0);
    access(1'b0, 32'h10, 32'h0);
    idle(2);
  endtask

  task automatic test_reset_mid_store;
    access(1'b1, 32'h20, 32'h11112222);
    @(posedge clk_i); #1;
    mem_read_i = 1'b0; mem_write_i = 1'b1; addr_i = 32'h20; data_i = 32'haaaa5555;
    @(posedge clk_i);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    #1;
    checks++;
    if (stall_o !== 1'b0 || ack_o !== 1'b0 || data_o !== 32'h0) begin
      errors++; $display("FAIL mid_reset got stall=%b ack=%b data=%h exp 0 0 0", stall_o, ack_o, data_o);
    end
    mem_write_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1;
    last_ld = 32'h0;
    for (int k = 0; k < L + 2; k++) begin
      @(negedge clk_i);
      checks++;
      if (stall_o !== 1'b0 || ack_o !== 1'b0) begin
        errors++; $display("FAIL post_reset k=%0d got stall=%b ack=%b exp 0 0", k, stall_o, ack_o);
      end
    end
    access(1'b0, 32'h20, 32'h0);
    idle(1);
  endtask

  task automatic test_latency1;
    for (int op = 0; op < 2; op++) begin
      @(posedge clk_i); #1;
      wr1 = (op == 0); rd1 = (op == 1); addr1 = 32'h8; data1 = 32'hcafef00d;
      for (int k = 0; k <= 2; k++) begin
        @(negedge clk_i);
        checks++;
        if (stall1 !== (k <= 1) || ack1 !== (k == 2)) begin
          errors++; $display("FAIL lat1 op=%0d k=%0d got stall=%b ack=%b exp %b %b", op, k, stall1, ack1, (k <= 1), (k == 2));
        end
      end
      checks++;
      if (dout1 !== ((op == 1) ? 32'hcafef00d : 32'h0)) begin
        errors++; $display("FAIL lat1_data op=%0d got %h", op, dout1);
      end
    end
    @(posedge clk_i); #1;
    rd1 = 1'b0; wr1 = 1'b0;
  endtask

  initial begin
    test_reset;
    test_store_load;
    test_wrap;
    test_misaligned;
    test_both;
    test_back_to_back;
    test_reset_mid_store;
    test_latency1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
